// File: rtl/button_seq_player_pkg.sv
// Shared encodings for the button sequence player: FSM states, active-low
// button drive codes, symbol values and the lock's correct combination.
package button_seq_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam logic [1:0] BTN_IDLE  = 2'b11;
   localparam logic [1:0] BTN_A_LOW = 2'b10;
   localparam logic [1:0] BTN_B_LOW = 2'b01;

   localparam logic SYM_A = 1'b0;
   localparam logic SYM_B = 1'b1;

   // Lock combination B,A,A,B,A packed LSB-first
   localparam logic [7:0] LOCK_SEQ_BITS = 8'h09;
   localparam logic [3:0] LOCK_SEQ_LEN  = 4'd5;

   function automatic logic [1:0] sym_to_btn(input logic sym);
      logic [1:0] btn;
      if (sym == SYM_B) begin
         btn = BTN_B_LOW;
      end else begin
         btn = BTN_A_LOW;
      end
      return btn;
   endfunction

endpackage

// File: rtl/button_seq_player_timer.sv
// Phase timer shared by the press and gap phases: clear, increment and a
// terminal-count flag at a limit chosen by the caller each cycle.
module seq_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_div,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;

   // Phase counter; clear takes priority over increment
   always_ff @(posedge clk_div or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/button_seq_player.sv
// Replays a latched sequence of A/B presses onto two active-low button lines,
// timed so a 16-sample debouncer sees exactly one press per symbol.
module button_seq_player
   import button_seq_player_pkg::*;
#(
   parameter int SEQ_MAX  = 8,
   parameter int HOLD_CYC = 20,
   parameter int GAP_CYC  = 20,
   parameter int CNT_W    = 8
) (
   input  logic               clk_div,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [3:0]         seq_len,
   input  logic [SEQ_MAX-1:0] seq_bits,
   output logic [1:0]         button_out,
   output logic               busy,
   output logic               done,
   output logic [2:0]         sym_idx
);

   localparam logic [3:0]       LEN_MAX  = 4'(SEQ_MAX);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC - 1);

   state_e             r_state;
   logic [1:0]         r_btn;
   logic               r_busy;
   logic               r_done;
   logic [2:0]         r_sym_idx;
   logic [SEQ_MAX-1:0] r_bits;
   logic [3:0]         r_len;

   logic [3:0]         w_len_clamp;
   logic [2:0]         w_next_idx;
   logic               w_last;
   logic               w_tc;
   logic               w_tmr_clear;
   logic               w_tmr_inc;
   logic [CNT_W-1:0]   w_limit;

   // Oversized lengths play the full sequence register
   always_comb begin
      w_len_clamp = seq_len;
      if (seq_len > LEN_MAX) begin
         w_len_clamp = LEN_MAX;
      end else begin
         w_len_clamp = seq_len;
      end
   end

   assign w_next_idx = r_sym_idx + 3'd1;
   assign w_last     = ({1'b0, r_sym_idx} == (r_len - 4'd1));

   // Timer control: counts only while a phase is running, restarts at each boundary
   always_comb begin
      w_limit     = HOLD_LIM;
      w_tmr_inc   = 1'b0;
      w_tmr_clear = 1'b1;
      case (r_state)
         ST_PRESS: begin
            w_limit     = HOLD_LIM;
            w_tmr_inc   = 1'b1;
            w_tmr_clear = abort | w_tc;
         end
         ST_GAP: begin
            w_limit     = GAP_LIM;
            w_tmr_inc   = 1'b1;
            w_tmr_clear = abort | w_tc;
         end
         default: begin
            w_limit     = HOLD_LIM;
            w_tmr_inc   = 1'b0;
            w_tmr_clear = 1'b1;
         end
      endcase
   end

   seq_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_div (clk_div),
      .reset   (reset),
      .i_clear (w_tmr_clear),
      .i_inc   (w_tmr_inc),
      .i_limit (w_limit),
      .o_tc    (w_tc)
   );

   // Playback FSM with registered button drive and status
   always_ff @(posedge clk_div or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_btn     <= BTN_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sym_idx <= 3'd0;
         r_bits    <= '0;
         r_len     <= 4'd0;
      end else if (abort) begin
         r_state   <= ST_IDLE;
         r_btn     <= BTN_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sym_idx <= 3'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_len_clamp != 4'd0) begin
                     r_bits    <= seq_bits;
                     r_len     <= w_len_clamp;
                     r_sym_idx <= 3'd0;
                     r_busy    <= 1'b1;
                     r_state   <= ST_PRESS;
                     r_btn     <= sym_to_btn(seq_bits[0]);
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_PRESS: begin
               if (w_tc) begin
                  r_btn   <= BTN_IDLE;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_tc) begin
                  if (w_last) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_sym_idx <= w_next_idx;
                     r_state   <= ST_PRESS;
                     r_btn     <= sym_to_btn(r_bits[w_next_idx]);
                  end
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_btn     <= BTN_IDLE;
               r_busy    <= 1'b0;
               r_sym_idx <= 3'd0;
            end
         endcase
      end
   end

   assign button_out = r_btn;
   assign busy       = r_busy;
   assign done       = r_done;
   assign sym_idx    = r_sym_idx;

endmodule

// File: doc/button_seq_player.md
Name: button_seq_player

Overview:
- Transmitter counterpart to the debounced button receiver in the combination-lock design.
- Replays a programmed sequence of button presses onto two active-low button lines (A = bit 0, B = bit 1).
- Each press is held, then released, long enough for the 16-sample debouncer to register exactly one press per symbol.
- Used as an auto-demo / self-test driver, muxed onto the lock's button inputs, running on the same divided clock.

Parameters:
SEQ_MAX, 8, maximum symbols per sequence (seq_bits width)
HOLD_CYC, 20, clk_div cycles a button is held low per press (must be >=17)
GAP_CYC, 20, clk_div cycles both lines are high after each press (must be >=17)
CNT_W, 8, width of hold/gap counter (must hold max(HOLD_CYC,GAP_CYC)-1)

Ports:
clk_div  input  1  block clock (divided system clock)
reset  input  1  asynchronous, active-low reset
start  input  1  begin playback; sampled in IDLE only
abort  input  1  synchronous stop; returns to IDLE, no done
seq_len  input  4  number of symbols, 0..8; values >8 clamp to 8
seq_bits  input  SEQ_MAX  symbol i = seq_bits[i]; 1 = button B, 0 = button A
button_out  output  2  active-low button drive, idle 2'b11
busy  output  1  high from start acceptance until done/abort
done  output  1  one-cycle pulse after last gap completes
sym_idx  output  3  index of symbol currently being played

Behaviour:
- Interface: reset is asynchronous, active-low; clock is clk_div.
- Reset values: button_out=2'b11, busy=0, done=0, sym_idx=0, state=IDLE, counter=0. Reset asserted mid-playback forces these immediately (async); release is never glitched low.
- All outputs are registered.
- States: IDLE, PRESS, GAP.
- IDLE:
  - start=1 and clamped len>0: at that edge, latch seq_bits and len; sym_idx=0; counter=0; busy=1; state=PRESS; drive symbol 0 low (B -> 2'b01, A -> 2'b10).
  - start=1 and len=0: done=1 for one cycle; busy stays 0; no press.
- PRESS:
  - counter increments each edge.
  - At counter==HOLD_CYC-1: button_out=2'b11, counter=0, state=GAP.
  - Line is low for exactly HOLD_CYC cycles.
- GAP:
  - counter increments each edge.
  - At counter==GAP_CYC-1 and sym_idx==len-1: state=IDLE, busy=0, done=1 for one cycle.
  - Otherwise at counter==GAP_CYC-1: sym_idx+1, counter=0, state=PRESS, next symbol driven low.
- Timing: total time from start edge to done edge is len*(HOLD_CYC+GAP_CYC) cycles.
- Exactly one line is ever low; 2'b00 is never driven.
- start while busy: ignored. Latched sequence is immune to seq_bits/seq_len changes during playback.
- abort=1 in any state: next edge forces button_out=2'b11, busy=0, sym_idx=0, state=IDLE, done=0. abort has priority over start in the same cycle.
- done and busy are never both 1.

Decomposition:
- Shared package: state encodings (IDLE/PRESS/GAP), BTN_IDLE=2'b11, BTN_A_LOW=2'b10, BTN_B_LOW=2'b01, SYM_A=0, SYM_B=1.
- Also in the package: the lock's correct combination, B,A,A,B,A (seq_bits=8'h09, len=5), for reuse by benches and top level.
- One natural sub-module: seq_phase_timer (load/clear, increment, terminal-count flag at a programmable limit), instantiated once and shared between PRESS and GAP.

Test Plan:
- Reset, then start with seq_len=5, seq_bits=8'h09 -> button_out pattern 01,10,10,01,10. Each low for 20 cycles, each followed by 20 cycles of 11. done pulses 200 cycles after start; busy high throughout.
- Player output fed into two debounced-button receivers plus the lock FSM, same code -> receivers emit exactly 5 pressed pulses; lock reaches CORRECT display.
- seq_len=0 with start -> done=1 for one cycle next edge; busy stays 0; button_out stays 11.
- seq_len=12, seq_bits=8'hFF -> exactly 8 B presses (button_out=01 eight times); seq_bits changed mid-run has no effect.
- abort asserted 5 cycles into the third press -> button_out=11 next edge, busy=0, no done. A following start replays from symbol 0.
- reset deasserted-to-asserted during a press -> button_out=11 asynchronously. start during busy is ignored (press count unchanged).
